aes_inv_key_stream: RTL and testbench

//  Sequential AES-128 round-key generator for the decrypt datapath: takes the cipher key,

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/aes_key_step.sv | 36 +++
 rtl/aes_inv_key_stream.sv | 96 +++++++++
 tb/tb_aes_inv_key_stream.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse key-stream block: S-box, Rcon,
// column packing helpers and the controller state type.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Keys travel as a row-major byte matrix; a word is one column, row 0 in the MSB.
    function automatic logic [31:0] get_col(input logic [127:0] key, input int c);
        return {key[127-8*c -: 8], key[95-8*c -: 8], key[63-8*c -: 8], key[31-8*c -: 8]};
    endfunction

    function automatic logic [127:0] pack_cols(input logic [31:0] c0, input logic [31:0] c1,
                                               input logic [31:0] c2, input logic [31:0] c3);
        return {c0[31:24], c1[31:24], c2[31:24], c3[31:24],
                c0[23:16], c1[23:16], c2[23:16], c3[23:16],
                c0[15:8],  c1[15:8],  c2[15:8],  c3[15:8],
                c0[7:0],   c1[7:0],   c2[7:0],   c3[7:0]};
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (dir_i=0) or inverse (dir_i=1),
// sharing a single SubWord column between both directions.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [3:0]   round_i,
    input  logic         dir_i,
    output logic [127:0] next_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] v1, v2, v3;
    logic [31:0] sub_in, t, n0, n1, n2, n3;

    assign w0 = get_col(key_i, 0);
    assign w1 = get_col(key_i, 1);
    assign w2 = get_col(key_i, 2);
    assign w3 = get_col(key_i, 3);

    // Going backwards, the previous key's last column is recovered first and feeds the S-box.
    assign v3 = w3 ^ w2;
    assign v2 = w2 ^ w1;
    assign v1 = w1 ^ w0;

    assign sub_in = dir_i ? v3 : w3;
    assign t      = sub_rot_word(sub_in) ^ {rcon(round_i), 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_o = dir_i ? pack_cols(n0, v1, v2, v3) : pack_cols(n0, n1, n2, n3);

endmodule

// File: rtl/aes_inv_key_stream.sv
// Sequential AES-128 decrypt key generator: expands forward to round key 10,
// then streams keys 10..0 over a valid/ready handshake using the inverse schedule.
module aes_inv_key_stream
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t       state_q;
    logic [127:0] key_q, key_out_q, key_step_d;
    logic [3:0]   rnd_q, round_q, step_round;
    logic         valid_q, busy_q, done_q, step_dir, transfer;

    assign step_dir   = (state_q == STREAM);
    assign step_round = step_dir ? round_q : rnd_q;
    assign transfer   = valid_q & key_ready;

    aes_key_step u_step (
        .key_i   (key_q),
        .round_i (step_round),
        .dir_i   (step_dir),
        .next_o  (key_step_d)
    );

    // EXPAND runs rnd 1..NR as forward steps, then spends one more cycle publishing key NR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            key_q     <= '0;
            key_out_q <= '0;
            rnd_q     <= '0;
            round_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q   <= key_in;
                        rnd_q   <= 4'd1;
                        busy_q  <= 1'b1;
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (rnd_q <= LAST_ROUND) begin
                        key_q <= key_step_d;
                        rnd_q <= rnd_q + 4'd1;
                    end else begin
                        key_out_q <= key_q;
                        round_q   <= LAST_ROUND;
                        valid_q   <= 1'b1;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        if (round_q != 4'd0) begin
                            key_q     <= key_step_d;
                            key_out_q <= key_step_d;
                            round_q   <= round_q - 4'd1;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_out   = key_out_q;
    assign key_round = round_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_stream.sv
// Self-checking bench for aes_inv_key_stream against a textbook AES-128 key
// expansion whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_key_stream;

    logic         clk = 1'b0;
    logic         rst_n, start, key_ready;
    logic [127:0] key_in, key_out;
    logic [3:0]   key_round;
    logic         key_valid, busy, done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_m [11];
    logic [127:0] mdl [11];
    logic [127:0] beat_key [16];
    logic [3:0]   beat_rnd [16];

    always #5 clk = ~clk;

    aes_inv_key_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .key_out   (key_out),
        .key_round (key_round),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: GF(2^8) arithmetic and the FIPS-197 word recurrence
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic build_tables();
        logic [7:0] inv, rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc = 8'h01;
        rcon_m[0] = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            rcon_m[i] = rc;
            rc = xtime(rc);
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [127:0] rk;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                w[c][31-8*row -: 8] = k[127-32*row-8*c -: 8];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]}
                    ^ {rcon_m[i/4], 24'h000000};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            rk = '0;
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    rk[127-32*row-8*c -: 8] = w[4*r+c][31-8*row -: 8];
            mdl[r] = rk;
        end
    endtask

    // Drives one run from a negedge with the DUT idle and records every transferred beat.
    task automatic run_stream(input logic [127:0] k, input int ready_pct, input bit noisy,
                              input bit start_on_last, input int abort_round,
                              output int latency, output int nbeats, output int stall_err,
                              output bit timed_out);
        logic [127:0] held_key;
        logic [3:0]   held_rnd;
        bit           stalled, rdy, last;
        int           iter;
        latency = 0; nbeats = 0; stall_err = 0; timed_out = 1'b0;
        stalled = 1'b0; held_key = '0; held_rnd = '0; iter = 0;
        key_in = k; start = 1'b1; key_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        key_in = rand_key();
        while (!key_valid && !timed_out) begin
            if (latency >= 40) timed_out = 1'b1;
            else begin
                start  = noisy && ($urandom_range(2) == 0);
                key_in = rand_key();
                @(negedge clk);
                latency++;
            end
        end
        while (!timed_out) begin
            if (!key_valid) break;
            if (abort_round >= 0 && int'(key_round) == abort_round) begin
                rst_n = 1'b0;
                break;
            end
            if (stalled && (key_out !== held_key || key_round !== held_rnd)) stall_err++;
            rdy       = ($urandom_range(99) < ready_pct);
            key_ready = rdy;
            last      = rdy && (key_round == 4'd0);
            start     = last ? start_on_last : (noisy && ($urandom_range(2) == 0));
            key_in    = rand_key();
            if (rdy && nbeats < 16) begin
                beat_key[nbeats] = key_out;
                beat_rnd[nbeats] = key_round;
                nbeats++;
            end
            stalled = !rdy; held_key = key_out; held_rnd = key_round;
            @(negedge clk);
            iter++;
            if (last) break;
            if (iter >= 400) timed_out = 1'b1;
        end
        key_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (key_out !== 128'h0) begin errors++; $display("[TB] FAIL reset_key_out: got %h expected 0", key_out); end
        checks++;
        if (key_round !== 4'd0) begin errors++; $display("[TB] FAIL reset_key_round: got %0d expected 0", key_round); end
        checks++;
        if ({key_valid, busy, done} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: got valid/busy/done %b expected 000", {key_valid, busy, done});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({key_valid, busy, done} !== 3'b000) begin
            errors++; $display("[TB] FAIL idle_after_reset: got valid/busy/done %b expected 000", {key_valid, busy, done});
        end
    endtask

    task automatic test_fips();
        logic [127:0] k = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
        int lat, nb, se; bit to;
        model_expand(k);
        run_stream(k, 100, 1'b0, 1'b0, -1, lat, nb, se, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("[TB] FAIL fips_timeout: got %0d expected 0", to); end
        checks++;
        if (lat != 11) begin errors++; $display("[TB] FAIL fips_latency: got %0d expected 11", lat); end
        checks++;
        if (nb != 11) begin errors++; $display("[TB] FAIL fips_beats: got %0d expected 11", nb); end
        checks++;
        if ({beat_rnd[0], beat_key[0]} !== {4'd10, 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6}) begin
            errors++; $display("[TB] FAIL fips_round10: got %0d/%h expected 10/d0c9e1b614ee3f63f9250c0ca889c8a6", beat_rnd[0], beat_key[0]);
        end
        for (int b = 1; b < 10; b++) begin
            checks++;
            if ({beat_rnd[b], beat_key[b]} !== {4'(10 - b), mdl[10-b]}) begin
                errors++; $display("[TB] FAIL fips_beat%0d: got %0d/%h expected %0d/%h", b, beat_rnd[b], beat_key[b], 10 - b, mdl[10-b]);
            end
        end
        checks++;
        if ({beat_rnd[10], beat_key[10]} !== {4'd0, k}) begin
            errors++; $display("[TB] FAIL fips_round0: got %0d/%h expected 0/%h", beat_rnd[10], beat_key[10], k);
        end
        checks++;
        if ({done, busy, key_valid} !== 3'b100) begin
            errors++; $display("[TB] FAIL fips_done: got done/busy/valid %b expected 100", {done, busy, key_valid});
        end
        checks++;
        if (key_out !== k) begin errors++; $display("[TB] FAIL fips_idle_hold: got %h expected %h", key_out, k); end
        @(negedge clk);
    endtask

    task automatic test_random_keys();
        logic [127:0] k;
        int lat, nb, se; bit to;
        for (int n = 0; n < 100; n++) begin
            k = rand_key();
            model_expand(k);
            run_stream(k, 100, 1'b0, 1'b0, -1, lat, nb, se, to);
            checks++;
            if (to !== 1'b0 || lat != 11 || nb != 11) begin
                errors++; $display("[TB] FAIL rand%0d_shape: got timeout %0d latency %0d beats %0d expected 0/11/11", n, to, lat, nb);
            end
            for (int b = 0; b < 11; b++) begin
                checks++;
                if ({beat_rnd[b], beat_key[b]} !== {4'(10 - b), mdl[10-b]}) begin
                    errors++; $display("[TB] FAIL rand%0d_beat%0d: got %0d/%h expected %0d/%h", n, b, beat_rnd[b], beat_key[b], 10 - b, mdl[10-b]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] k;
        int lat, nb, se; bit to;
        for (int n = 0; n < 15; n++) begin
            k = rand_key();
            model_expand(k);
            run_stream(k, 40, 1'b0, 1'b0, -1, lat, nb, se, to);
            checks++;
            if (to !== 1'b0 || nb != 11) begin
                errors++; $display("[TB] FAIL bp%0d_shape: got timeout %0d beats %0d expected 0/11", n, to, nb);
            end
            checks++;
            if (se != 0) begin errors++; $display("[TB] FAIL bp%0d_stable: got %0d changes while stalled expected 0", n, se); end
            for (int b = 0; b < 11; b++) begin
                checks++;
                if ({beat_rnd[b], beat_key[b]} !== {4'(10 - b), mdl[10-b]}) begin
                    errors++; $display("[TB] FAIL bp%0d_beat%0d: got %0d/%h expected %0d/%h", n, b, beat_rnd[b], beat_key[b], 10 - b, mdl[10-b]);
                end
            end
        end
    endtask

    task automatic test_start_ignore();
        logic [127:0] k;
        int lat, nb, se; bit to;
        k = rand_key();
        model_expand(k);
        run_stream(k, 70, 1'b1, 1'b1, -1, lat, nb, se, to);
        checks++;
        if (to !== 1'b0 || lat != 11 || nb != 11 || se != 0) begin
            errors++; $display("[TB] FAIL ign_shape: got timeout %0d latency %0d beats %0d stall %0d expected 0/11/11/0", to, lat, nb, se);
        end
        for (int b = 0; b < 11; b++) begin
            checks++;
            if ({beat_rnd[b], beat_key[b]} !== {4'(10 - b), mdl[10-b]}) begin
                errors++; $display("[TB] FAIL ign_beat%0d: got %0d/%h expected %0d/%h", b, beat_rnd[b], beat_key[b], 10 - b, mdl[10-b]);
            end
        end
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("[TB] FAIL ign_done: got done/busy %b expected 10", {done, busy}); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({done, busy, key_valid} !== 3'b000) begin
                errors++; $display("[TB] FAIL ign_last_start_c%0d: got done/busy/valid %b expected 000", c, {done, busy, key_valid});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka, kb;
        int lat, nb, se; bit to;
        ka = rand_key(); kb = rand_key();
        model_expand(ka);
        run_stream(ka, 100, 1'b0, 1'b0, -1, lat, nb, se, to);
        checks++;
        if (to !== 1'b0 || nb != 11 || beat_key[10] !== ka) begin
            errors++; $display("[TB] FAIL b2b_first: got timeout %0d beats %0d last %h expected 0/11/%h", to, nb, beat_key[10], ka);
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done: got %0d expected 1", done); end
        model_expand(kb);
        run_stream(kb, 100, 1'b0, 1'b0, -1, lat, nb, se, to);
        checks++;
        if (to !== 1'b0 || lat != 11 || nb != 11) begin
            errors++; $display("[TB] FAIL b2b_second: got timeout %0d latency %0d beats %0d expected 0/11/11", to, lat, nb);
        end
        for (int b = 0; b < 11; b++) begin
            checks++;
            if ({beat_rnd[b], beat_key[b]} !== {4'(10 - b), mdl[10-b]}) begin
                errors++; $display("[TB] FAIL b2b_beat%0d: got %0d/%h expected %0d/%h", b, beat_rnd[b], beat_key[b], 10 - b, mdl[10-b]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        logic [127:0] k;
        int lat, nb, se; bit to;
        key_in = rand_key(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({key_out, key_round, key_valid, busy, done} !== 135'h0) begin
            errors++; $display("[TB] FAIL abort_expand: got %h/%0d/%b expected all zero", key_out, key_round, {key_valid, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("[TB] FAIL abort_expand_nodone: got done/busy %b expected 00", {done, busy}); end

        k = rand_key();
        run_stream(k, 100, 1'b0, 1'b0, 6, lat, nb, se, to);
        #1;
        checks++;
        if (nb != 4 || to !== 1'b0) begin errors++; $display("[TB] FAIL abort_stream_beats: got %0d timeout %0d expected 4/0", nb, to); end
        checks++;
        if ({key_out, key_round, key_valid, busy, done} !== 135'h0) begin
            errors++; $display("[TB] FAIL abort_stream: got %h/%0d/%b expected all zero", key_out, key_round, {key_valid, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_stream_nodone: got %0d expected 0", done); end

        k = rand_key();
        model_expand(k);
        run_stream(k, 100, 1'b0, 1'b0, -1, lat, nb, se, to);
        checks++;
        if (to !== 1'b0 || lat != 11 || nb != 11) begin
            errors++; $display("[TB] FAIL abort_rerun_shape: got timeout %0d latency %0d beats %0d expected 0/11/11", to, lat, nb);
        end
        for (int b = 0; b < 11; b++) begin
            checks++;
            if ({beat_rnd[b], beat_key[b]} !== {4'(10 - b), mdl[10-b]}) begin
                errors++; $display("[TB] FAIL abort_rerun_beat%0d: got %0d/%h expected %0d/%h", b, beat_rnd[b], beat_key[b], 10 - b, mdl[10-b]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero_key();
        int lat, nb, se; bit to;
        model_expand(128'h0);
        run_stream(128'h0, 100, 1'b0, 1'b0, -1, lat, nb, se, to);
        checks++;
        if (to !== 1'b0 || nb != 11) begin errors++; $display("[TB] FAIL zero_shape: got timeout %0d beats %0d expected 0/11", to, nb); end
        checks++;
        if (beat_key[0][127:120] !== 8'hb4) begin
            errors++; $display("[TB] FAIL zero_r10_msb: got %h expected b4", beat_key[0][127:120]);
        end
        for (int b = 0; b < 11; b++) begin
            checks++;
            if ({beat_rnd[b], beat_key[b]} !== {4'(10 - b), mdl[10-b]}) begin
                errors++; $display("[TB] FAIL zero_beat%0d: got %0d/%h expected %0d/%h", b, beat_rnd[b], beat_key[b], 10 - b, mdl[10-b]);
            end
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done_rise: got %0d expected 1", done); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_width: got %0d expected 0", done); end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_fips();
        test_random_keys();
        test_backpressure();
        test_start_ignore();
        test_back_to_back();
        test_reset_midrun();
        test_zero_key();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
